// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// id_hazard_ctrl : decode-stage scoreboard; RAW/WAW stall, issue, write gating.
// Optional same-cycle writeback bypass enabled by defining ID_WB_BYPASS_EN.
// Rev 1.0
// ============================================================================
module id_hazard_ctrl #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             flush,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             use1,
    input  logic             use2,
    input  logic [AW-1:0]    wa3_id,
    input  logic             we3_id,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_wa,
    output logic             stall,
    output logic             issue,
    output logic             we3_gated,
    output logic             fwd1,
    output logic             fwd2,
    output logic [NREGS-1:0] busy_vec,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_rd1_haz;
    logic             w_rd2_haz;
    logic             w_wr_haz;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;

    // Register 0 is never tracked, so its busy bit is ignored on every lookup.
    assign w_rd1_haz = use1   && (ra1    != '0) && r_busy[ra1];
    assign w_rd2_haz = use2   && (ra2    != '0) && r_busy[ra2];
    assign w_wr_haz  = we3_id && (wa3_id != '0) && r_busy[wa3_id];

`ifdef ID_WB_BYPASS_EN
    logic w_wb_hit1;
    logic w_wb_hit2;
    logic w_wb_hit3;

    assign w_wb_hit1 = wb_we && (wb_wa == ra1);
    assign w_wb_hit2 = wb_we && (wb_wa == ra2);
    assign w_wb_hit3 = wb_we && (wb_wa == wa3_id);

    // A write retiring this cycle resolves the hazard; operands take wd3.
    assign w_raw1 = w_rd1_haz && !w_wb_hit1;
    assign w_raw2 = w_rd2_haz && !w_wb_hit2;
    assign w_waw  = w_wr_haz  && !w_wb_hit3;
    assign fwd1   = use1 && (ra1 != '0) && w_wb_hit1;
    assign fwd2   = use2 && (ra2 != '0) && w_wb_hit2;
`else
    assign w_raw1 = w_rd1_haz;
    assign w_raw2 = w_rd2_haz;
    assign w_waw  = w_wr_haz;
    assign fwd1   = 1'b0;
    assign fwd2   = 1'b0;
`endif

    assign stall     = id_valid && !flush && (w_raw1 || w_raw2 || w_waw);
    assign issue     = id_valid && !flush && !stall;
    assign we3_gated = issue && we3_id && (wa3_id != '0);

    // Set is applied after clear: the issuing write is younger than the retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_we && (wb_wa != '0)) begin
            w_busy_nxt[wb_wa] = 1'b0;
        end
        if (we3_gated) begin
            w_busy_nxt[wa3_id] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    assign busy_vec  = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
